// File: rtl/count_pkg.sv
// Shared types and helpers for the count-bus receive checker.
// Lane order on the bus is a=7:0, b=15:8, c=23:16, d=31:24.
package count_pkg;

    localparam int COUNT_W = 32;
    localparam int LANE_W  = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [COUNT_W-1:0] assemble_lanes(
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic [LANE_W-1:0] c,
        input logic [LANE_W-1:0] d
    );
        return {d, c, b, a};
    endfunction

endpackage

// File: rtl/count_checker_if.sv
// Four-lane free-running count bus with its sample enable.
// The producer drives through master, the checker listens through slave.
interface count_checker_if;
    import count_pkg::*;

    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    logic [LANE_W-1:0] c;
    logic [LANE_W-1:0] d;
    logic              valid;

    modport master (output a, b, c, d, valid);
    modport slave  (input  a, b, c, d, valid);

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Receive-side checker: reassembles the count word, verifies +1 steps,
// tracks lock via HUNT/SYNC/LOCKED and counts mismatches seen while locked.
module count_checker
    import count_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    count_checker_if.slave     bus,
    output logic [COUNT_W-1:0] value,
    output logic               locked,
    output logic               mismatch,
    output logic               wrap,
    output logic [ERR_W-1:0]   err_count
);

    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_TARGET = 8'(LOSS_COUNT);

    state_t               state_reg,    state_next;
    logic [COUNT_W-1:0]   value_reg,    value_next;
    logic [COUNT_W-1:0]   expected_reg, expected_next;
    logic [7:0]           good_cnt_reg, good_cnt_next;
    logic [7:0]           bad_cnt_reg,  bad_cnt_next;
    logic                 mismatch_reg, mismatch_next;
    logic                 wrap_reg,     wrap_next;
    logic                 err_inc;

    logic [COUNT_W-1:0]   sample;
    logic                 match;

    assign sample = assemble_lanes(bus.a, bus.b, bus.c, bus.d);
    assign match  = (sample == expected_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= HUNT;
            value_reg    <= '0;
            expected_reg <= '0;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            mismatch_reg <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            value_reg    <= value_next;
            expected_reg <= expected_next;
            good_cnt_reg <= good_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
            mismatch_reg <= mismatch_next;
            wrap_reg     <= wrap_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        value_next    = value_reg;
        expected_next = expected_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        mismatch_next = 1'b0;
        wrap_next     = 1'b0;
        err_inc       = 1'b0;

        if (bus.valid) begin
            // Re-seed on every accepted word, so a lone bad word costs two mismatches.
            value_next    = sample;
            expected_next = sample + 32'd1;

            case (state_reg)
                HUNT: begin
                    state_next    = SYNC;
                    good_cnt_next = '0;
                end
                SYNC: begin
                    if (match) begin
                        if (good_cnt_reg + 8'd1 >= LOCK_TARGET) begin
                            state_next    = LOCKED;
                            good_cnt_next = '0;
                            bad_cnt_next  = '0;
                        end else begin
                            good_cnt_next = good_cnt_reg + 8'd1;
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_cnt_next = '0;
                        // A matching word after all-ones can only be zero.
                        wrap_next    = (value_reg == {COUNT_W{1'b1}});
                    end else begin
                        mismatch_next = 1'b1;
                        err_inc       = 1'b1;
                        if (bad_cnt_reg + 8'd1 >= LOSS_TARGET) begin
                            state_next    = HUNT;
                            good_cnt_next = '0;
                            bad_cnt_next  = '0;
                        end else begin
                            bad_cnt_next = bad_cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count)
    );

    assign value    = value_reg;
    assign locked   = (state_reg == LOCKED);
    assign mismatch = mismatch_reg;
    assign wrap     = wrap_reg;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: a default build plus a narrow-counter,
// slow-loss build sharing one count bus.
module tb_count_checker;
    import count_pkg::*;

    logic        clk;
    logic        reset;
    count_checker_if bus();

    logic [31:0] value,   s_value;
    logic        locked,  s_locked;
    logic        mismatch, s_mismatch;
    logic        wrap,    s_wrap;
    logic [15:0] err_count;
    logic [1:0]  s_err_count;

    int checks = 0;
    int errors = 0;

    count_checker dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .value     (value),
        .locked    (locked),
        .mismatch  (mismatch),
        .wrap      (wrap),
        .err_count (err_count)
    );

    count_checker #(
        .LOCK_COUNT (4),
        .LOSS_COUNT (8),
        .ERR_W      (2)
    ) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .value     (s_value),
        .locked    (s_locked),
        .mismatch  (s_mismatch),
        .wrap      (s_wrap),
        .err_count (s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle at the falling edge, then settle just past the rising edge.
    task automatic step(input logic v, input logic [31:0] w);
        @(negedge clk);
        bus.valid = v;
        {bus.d, bus.c, bus.b, bus.a} = w;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        bus.valid = 1'b1;
        {bus.d, bus.c, bus.b, bus.a} = 32'hA5A5_5A5A;
        repeat (cycles) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        bus.valid = 1'b0;
    endtask

    // Seed then four correct increments: locked after base+4.
    task automatic lock_at(input logic [31:0] base);
        apply_reset(2);
        for (int i = 0; i < 5; i++) step(1'b1, base + 32'(i));
    endtask

    task automatic test_reset;
        apply_reset(2);
        checks++;
        if (value !== 32'h0 || locked !== 1'b0 || mismatch !== 1'b0 || wrap !== 1'b0 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: value=%h locked=%b mismatch=%b wrap=%b err=%0d, want 0/0/0/0/0", value, locked, mismatch, wrap, err_count);
        end
        checks++;
        if (s_value !== 32'h0 || s_locked !== 1'b0 || s_err_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_state_sat: value=%h locked=%b err=%0d, want 0/0/0", s_value, s_locked, s_err_count);
        end
        $display("reset: value=%h locked=%b err=%0d", value, locked, err_count);
    endtask

    task automatic test_lock_acquire;
        apply_reset(2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h10 + 32'(i));
            checks++;
            if (locked !== 1'b0 || mismatch !== 1'b0) begin
                errors++;
                $display("FAIL lock_early_%0d: locked=%b mismatch=%b, want 0/0", i, locked, mismatch);
            end
        end
        step(1'b1, 32'h14);
        checks++;
        if (locked !== 1'b1 || err_count !== 16'h0 || value !== 32'h14) begin
            errors++;
            $display("FAIL lock_acquire: locked=%b err=%0d value=%h, want 1/0/00000014", locked, err_count, value);
        end
        $display("lock_acquire: value=%h locked=%b err=%0d", value, locked, err_count);
    endtask

    task automatic test_lane_carry;
        lock_at(32'h0000_FFF8);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h0000_FFFD + 32'(i));
            checks++;
            if (mismatch !== 1'b0 || locked !== 1'b1) begin
                errors++;
                $display("FAIL carry_%0d: mismatch=%b locked=%b, want 0/1", i, mismatch, locked);
            end
        end
        checks++;
        if (value !== 32'h0001_0002 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL carry_value: value=%h err=%0d, want 00010002/0", value, err_count);
        end
        $display("lane_carry: value=%h err=%0d", value, err_count);
    endtask

    task automatic test_wrap;
        int pulses;
        pulses = 0;
        lock_at(32'hFFFF_FFFB);
        step(1'b1, 32'h0000_0000);
        checks++;
        if (wrap !== 1'b1 || mismatch !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse: wrap=%b mismatch=%b locked=%b, want 1/0/1", wrap, mismatch, locked);
        end
        if (wrap === 1'b1) pulses++;
        step(1'b1, 32'h0000_0001);
        if (wrap === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || locked !== 1'b1 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL wrap_once: pulses=%0d locked=%b err=%0d, want 1/1/0", pulses, locked, err_count);
        end
        $display("wrap: pulses=%0d value=%h locked=%b", pulses, value, locked);
    endtask

    task automatic test_glitch_loss;
        lock_at(32'h1C);
        step(1'b1, 32'h21);
        checks++;
        if (mismatch !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL glitch_good: mismatch=%b locked=%b, want 0/1", mismatch, locked);
        end
        step(1'b1, 32'h99);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL glitch_bad: mismatch=%b err=%0d locked=%b, want 1/1/1", mismatch, err_count, locked);
        end
        step(1'b1, 32'h23);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 16'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL glitch_loss: mismatch=%b err=%0d locked=%b, want 1/2/0", mismatch, err_count, locked);
        end
        // Back in HUNT: this word only seeds, the next wrong one is a silent SYNC miss.
        step(1'b1, 32'h50);
        checks++;
        if (mismatch !== 1'b0 || locked !== 1'b0 || err_count !== 16'd2 || value !== 32'h50) begin
            errors++;
            $display("FAIL hunt_seed: mismatch=%b locked=%b err=%0d value=%h, want 0/0/2/00000050", mismatch, locked, err_count, value);
        end
        step(1'b1, 32'h77);
        checks++;
        if (mismatch !== 1'b0 || locked !== 1'b0 || err_count !== 16'd2) begin
            errors++;
            $display("FAIL sync_miss: mismatch=%b locked=%b err=%0d, want 0/0/2", mismatch, locked, err_count);
        end
        $display("glitch_loss: err=%0d locked=%b value=%h", err_count, locked, value);
    endtask

    task automatic test_valid_gap;
        lock_at(32'h40);
        step(1'b1, 32'h45);
        step(1'b0, 32'hDEAD_BEEF);
        checks++;
        if (mismatch !== 1'b0 || value !== 32'h45 || locked !== 1'b1) begin
            errors++;
            $display("FAIL gap_hold: mismatch=%b value=%h locked=%b, want 0/00000045/1", mismatch, value, locked);
        end
        step(1'b0, 32'h0000_0000);
        step(1'b1, 32'h46);
        checks++;
        if (mismatch !== 1'b0 || value !== 32'h46 || locked !== 1'b1 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL gap_resume: mismatch=%b value=%h locked=%b err=%0d, want 0/00000046/1/0", mismatch, value, locked, err_count);
        end
        $display("valid_gap: value=%h mismatch=%b", value, mismatch);
    endtask

    task automatic test_saturation;
        logic [31:0] words [5];
        logic [1:0]  want_err [5];
        words    = '{32'h0, 32'h0, 32'h5, 32'h5, 32'h5};
        want_err = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        lock_at(32'hFC);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, words[i]);
            checks++;
            if (s_mismatch !== 1'b1 || s_wrap !== 1'b0 || s_err_count !== want_err[i] || s_locked !== 1'b1) begin
                errors++;
                $display("FAIL sat_%0d: mismatch=%b wrap=%b err=%0d locked=%b, want 1/0/%0d/1", i, s_mismatch, s_wrap, s_err_count, s_locked, want_err[i]);
            end
            if (i == 1) begin
                checks++;
                if (locked !== 1'b0 || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_jump_loss: locked=%b wrap=%b, want 0/0", locked, wrap);
                end
            end
        end
        step(1'b0, 32'h0);
        checks++;
        if (s_err_count !== 2'd3 || s_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: err=%0d mismatch=%b, want 3/0", s_err_count, s_mismatch);
        end
        $display("saturation: err=%0d locked=%b", s_err_count, s_locked);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        reset = 1'b1;
        bus.valid = 1'b1;
        {bus.d, bus.c, bus.b, bus.a} = 32'h0000_0006;
        @(posedge clk);
        #1;
        checks++;
        if (s_locked !== 1'b0 || s_err_count !== 2'd0 || s_value !== 32'h0 || s_mismatch !== 1'b0 || s_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: locked=%b err=%0d value=%h mismatch=%b wrap=%b, want 0/0/0/0/0", s_locked, s_err_count, s_value, s_mismatch, s_wrap);
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h1234);
        checks++;
        if (s_mismatch !== 1'b0 || s_locked !== 1'b0 || s_value !== 32'h1234 || s_err_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_seed: mismatch=%b locked=%b value=%h err=%0d, want 0/0/00001234/0", s_mismatch, s_locked, s_value, s_err_count);
        end
        step(1'b1, 32'h9999);
        checks++;
        if (s_mismatch !== 1'b0 || s_err_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_sync: mismatch=%b err=%0d, want 0/0", s_mismatch, s_err_count);
        end
        $display("reset_mid: value=%h locked=%b err=%0d", s_value, s_locked, s_err_count);
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0;
        {bus.d, bus.c, bus.b, bus.a} = 32'h0;
        test_reset;
        test_lock_acquire;
        test_lane_carry;
        test_wrap;
        test_glitch_loss;
        test_valid_gap;
        test_saturation;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
